// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: who owns the RAM cycle, and the
// arbiter sequencing states.
package ram_port_arbiter_pkg;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } mem_owner_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  function automatic mem_owner_t other_owner(input mem_owner_t o);
    return (o == OWNER_CPU) ? OWNER_DBG : OWNER_CPU;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker used by the RAM port arbiter.
// Ports:
//   req_a   CPU request
//   req_b   debug request
//   force_b when both request, b wins outright (CPU halted)
//   last    owner of the previous grant, for round-robin
//   pick    chosen owner (OWNER_CPU when nobody requests; caller ignores it)
module rr_pick2
  import ram_port_arbiter_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       force_b,
  input  mem_owner_t last,
  output mem_owner_t pick
);

  always_comb begin
    pick = OWNER_CPU;
    if (req_b && !req_a) begin
      pick = OWNER_DBG;
    end else if (req_a && req_b) begin
      // contention: halted CPU yields, otherwise alternate away from last owner
      pick = force_b ? OWNER_DBG : other_owner(last);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the CPU memory path and the debug /
// program-loader port. Each access runs grant -> RAM cycle -> optional read
// wait -> response, one access at a time.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate and register RAM address/controls
// ACCESS  | RAM cycle; owner's gnt high, ram_we high for writes
// RD_WAIT | waiting out extra read latency; capture rdata when wait_cnt runs out
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request side (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata  CPU response side (pulses, held rdata)
//   dbg_req/we/addr/wdata        debug request side
//   dbg_gnt, dbg_rvalid, dbg_rdata  debug response side
//   cpu_halted                   debug gets absolute priority when high
//   ram_addr, ram_we, ram_wdata  registered RAM controls
//   ram_rdata                    RAM read data, sampled RD_LAT cycles after the address cycle
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              cpu_halted,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WAIT_W = $clog2(RD_LAT + 1);

  arb_state_t        state_q, state_d;
  mem_owner_t        last_owner_q, last_owner_d;
  mem_owner_t        pick;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              take;
  logic              capture;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req_a   (cpu_req),
    .req_b   (dbg_req),
    .force_b (cpu_halted),
    .last    (last_owner_q),
    .pick    (pick)
  );

  assign sel_we    = (pick == OWNER_CPU) ? cpu_we    : dbg_we;
  assign sel_addr  = (pick == OWNER_CPU) ? cpu_addr  : dbg_addr;
  assign sel_wdata = (pick == OWNER_CPU) ? cpu_wdata : dbg_wdata;

  // last_owner is updated at every grant, so during ACCESS/RD_WAIT it also
  // names the owner of the access in flight.
  assign cpu_gnt = (state_q == ACCESS) && (last_owner_q == OWNER_CPU);
  assign dbg_gnt = (state_q == ACCESS) && (last_owner_q == OWNER_DBG);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    wait_cnt_d   = wait_cnt_q;
    take         = 1'b0;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          take         = 1'b1;
          last_owner_d = pick;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (ram_we) begin
          state_d = IDLE;
        end else if (RD_LAT == 1) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = WAIT_W'(RD_LAT - 1);
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        // the decrement to zero happens on this edge: data is valid now
        if (wait_cnt_q == WAIT_W'(1)) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_DBG;
      wait_cnt_q   <= '0;
      ram_addr     <= '0;
      ram_we       <= 1'b0;
      ram_wdata    <= '0;
      cpu_rvalid   <= 1'b0;
      dbg_rvalid   <= 1'b0;
      cpu_rdata    <= '0;
      dbg_rdata    <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
      // the write strobe lives for the single ACCESS cycle that follows a take
      ram_we       <= take && sel_we;
      if (take) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      cpu_rvalid <= capture && (last_owner_q == OWNER_CPU);
      dbg_rvalid <= capture && (last_owner_q == OWNER_DBG);
      if (capture && (last_owner_q == OWNER_CPU)) begin
        cpu_rdata <= ram_rdata;
      end
      if (capture && (last_owner_q == OWNER_DBG)) begin
        dbg_rdata <= ram_rdata;
      end
    end
  end

endmodule
